// File: rtl/alu2_slice_sequencer.sv
// alu2_slice_sequencer: runs a WIDTH-bit ALU op LSB-first through one shared 2-bit slice
module alu2_slice_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_op,
  input  logic             req_mode,
  input  logic             req_cin,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  output logic [3:0]       slice_op,
  output logic             slice_mode,
  output logic             slice_cin,
  input  logic [1:0]       slice_f,
  input  logic             slice_cout,
  input  logic             slice_eq,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_eq,
  output logic             busy
);
  localparam int SLICES = WIDTH / 2;
  localparam int IW = SLICES > 1 ? $clog2(SLICES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, f_q;
  logic [3:0] op_q;
  logic mode_q, carry_q, eq_q;
  logic [IW-1:0] idx_q;
  logic run, done, last, accept;
  assign run = state_q == RUN;
  assign done = state_q == DONE;
  assign last = idx_q == IW'(SLICES - 1);
  assign req_ready = state_q == IDLE;
  assign accept = req_valid && req_ready;
  assign busy = run || done;
  assign slice_a = run ? a_q[{idx_q, 1'b0} +: 2] : 2'b0;
  assign slice_b = run ? b_q[{idx_q, 1'b0} +: 2] : 2'b0;
  assign slice_op = run ? op_q : 4'b0;
  assign slice_mode = run && mode_q;
  assign slice_cin = run && carry_q;
  assign rsp_valid = done;
  assign rsp_f = done ? f_q : '0;
  assign rsp_cout = done && carry_q;
  assign rsp_zero = done && f_q == '0;
  assign rsp_eq = done && eq_q;
  always_comb begin
    state_d = accept ? RUN : (run && last) ? DONE : (done && rsp_ready) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      f_q <= '0;
      op_q <= '0;
      mode_q <= 1'b0;
      carry_q <= 1'b0;
      eq_q <= 1'b1;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= req_a;
        b_q <= req_b;
        op_q <= req_op;
        mode_q <= req_mode;
        carry_q <= req_cin & req_mode;
        eq_q <= 1'b1;
        idx_q <= '0;
      end else if (run) begin
        f_q[{idx_q, 1'b0} +: 2] <= slice_f;
        carry_q <= slice_cout & mode_q;
        eq_q <= eq_q & slice_eq;
        idx_q <= last ? idx_q : idx_q + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu2_slice_sequencer.sv
// tb_alu2_slice_sequencer: scoreboard bench with a behavioural ADD/XOR slice
module tb_alu2_slice_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [7:0] req_a = '0, req_b = '0;
  logic [3:0] req_op = '0;
  logic req_mode = 1'b0, req_cin = 1'b0;
  logic [1:0] slice_a, slice_b, slice_f;
  logic [3:0] slice_op;
  logic slice_mode, slice_cin, slice_cout, slice_eq;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_f;
  logic rsp_cout, rsp_zero, rsp_eq, busy;
  int checks = 0, failures = 0;
  bit rand_ready = 1'b0;
  typedef struct packed {logic [7:0] f; logic c, z, e;} exp_t;
  exp_t q[$];
  alu2_slice_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_mode(req_mode), .req_cin(req_cin),
    .slice_a(slice_a), .slice_b(slice_b), .slice_op(slice_op), .slice_mode(slice_mode),
    .slice_cin(slice_cin), .slice_f(slice_f), .slice_cout(slice_cout), .slice_eq(slice_eq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_cout(rsp_cout),
    .rsp_zero(rsp_zero), .rsp_eq(rsp_eq), .busy(busy)
  );
  always #5 clk = ~clk;
  always_comb begin
    {slice_cout, slice_f} = slice_op == 4'd0 ? 3'(slice_a) + 3'(slice_b) + 3'(slice_cin) : {1'b0, slice_a ^ slice_b};
    slice_eq = slice_a == slice_b;
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [7:0] a, b, input logic [3:0] op, input logic m, cin);
    exp_t r;
    logic [8:0] s;
    r = '0;
    if (op == 4'd0 && m) begin
      s = {1'b0, a} + {1'b0, b} + 9'(cin);
      r.f = s[7:0];
      r.c = s[8];
    end else
      for (int i = 0; i < 4; i++) r.f[2*i +: 2] = op == 4'd0 ? a[2*i +: 2] + b[2*i +: 2] : a[2*i +: 2] ^ b[2*i +: 2];
    r.z = r.f == 8'h00;
    r.e = a == b;
    return r;
  endfunction
  task automatic push(input logic [7:0] f, input logic c, z, e);
    exp_t x;
    x.f = f; x.c = c; x.z = z; x.e = e;
    q.push_back(x);
  endtask
  always @(negedge clk)
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_rsp got=%0h exp=none", rsp_f);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_f", 32'(rsp_f), 32'(e.f));
        chk("rsp_cout", 32'(rsp_cout), 32'(e.c));
        chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
        chk("rsp_eq", 32'(rsp_eq), 32'(e.e));
      end
    end
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [7:0] a, b, input logic [3:0] op, input logic m, c);
    req_a = a; req_b = b; req_op = op; req_mode = m; req_cin = c; req_valid = 1'b1;
    for (int i = 0; i < 100 && !req_ready; i++) tick;
    chk("accept_wait", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
  endtask
  task automatic wait_valid;
    for (int i = 0; i < 50 && !rsp_valid; i++) tick;
    chk("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask
  task automatic run_op(input logic [7:0] a, b, input logic [3:0] op, input logic m, c);
    issue(a, b, op, m, c);
    wait_valid;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] av, ra, rb;
    logic [3:0] rop;
    logic rm, rc;
    tick; tick;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp", {rsp_f, rsp_cout, rsp_zero, rsp_eq}, 32'd0);
    chk("rst_slice", {slice_a, slice_b, slice_op, slice_mode, slice_cin}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick;
    av = 8'hA5;
    push(8'hE1, 1'b0, 1'b0, 1'b0);
    issue(8'hA5, 8'h3C, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("slice_a_seq", 32'(slice_a), 32'(av[2*i +: 2]));
      chk("early_valid", 32'(rsp_valid), 32'd0);
      tick;
    end
    chk("latency", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    push(8'h00, 1'b1, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 4'd0, 1'b1, 1'b0);
    push(8'h01, 1'b0, 1'b0, 1'b1);
    run_op(8'h00, 8'h00, 4'd0, 1'b1, 1'b1);
    push(8'h00, 1'b0, 1'b1, 1'b1);
    issue(8'h5A, 8'h5A, 4'd1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("logic_cin", 32'(slice_cin), 32'd0);
      tick;
    end
    wait_valid;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    push(8'h46, 1'b0, 1'b0, 1'b0);
    issue(8'h12, 8'h34, 4'd0, 1'b1, 1'b0);
    req_a = 8'h77; req_b = 8'h11; req_valid = 1'b1;
    wait_valid;
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp", {rsp_f, rsp_cout, rsp_zero, rsp_eq}, {8'h46, 3'b000});
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      tick;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) tick;
    chk("no_extra", 32'(rsp_valid), 32'd0);
    issue(8'h11, 8'h22, 4'd3, 1'b1, 1'b1);
    tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_slice", {slice_a, slice_b, slice_op, slice_mode, slice_cin}, 32'd0);
    chk("abort_rsp", {rsp_f, rsp_cout, rsp_zero, rsp_eq}, 32'd0);
    push(8'h30, 1'b0, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 4'd0, 1'b1, 1'b0);
    rand_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom);
      rb = n % 5 == 0 ? ra : 8'($urandom);
      rop = 4'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      q.push_back(model(ra, rb, rop, rm, rc));
      issue(ra, rb, rop, rm, rc);
    end
    for (int i = 0; i < 500 && q.size() != 0; i++) tick;
    chk("drain", 32'(q.size()), 32'd0);
    rand_ready = 1'b0;
    rsp_ready = 1'b0;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu2_slice_sequencer.md
Name: alu2_slice_sequencer

Overview:
Sequences one combinational 2-bit ALU slice, time-multiplexed, to perform a WIDTH-bit ALU operation. Each cycle it presents one 2-bit operand slice, LSB first, and chains the slice carry through a register. It collects the result bits, carry and flags, then returns them over a valid/ready response port. It sits between a requester (bus-side or test harness) and a single shared alu2 slice instance.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2; SLICES = WIDTH/2 (derived).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
req_op  in  4  slice function select, passed through unchanged
req_mode  in  1  1 = arithmetic (carry chained), 0 = logic (carry forced 0)
req_cin  in  1  initial carry-in
slice_a  out  2  A bits [2i+1:2i] to the slice
slice_b  out  2  B bits [2i+1:2i] to the slice
slice_op  out  4  function select to the slice
slice_mode  out  1  mode to the slice
slice_cin  out  1  chained carry to the slice
slice_f  in  2  slice result
slice_cout  in  1  slice carry-out
slice_eq  in  1  slice A==B indication
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_f  out  WIDTH  assembled result
rsp_cout  out  1  final carry-out
rsp_zero  out  1  rsp_f == 0
rsp_eq  out  1  AND of all slice_eq
busy  out  1  high in RUN or DONE

Behaviour:
- One clock. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - state = IDLE.
  - req_ready = 1.
  - rsp_valid = 0; rsp_f, rsp_cout, rsp_zero and rsp_eq = 0.
  - All slice_* = 0.
  - Slice index = 0, carry register = 0, eq accumulator = 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready = 1; slice_* driven 0.
  - On req_valid & req_ready: latch a, b, op and mode; carry_q <= req_cin & req_mode; idx <= 0; eq_q <= 1; state <= RUN.
- RUN:
  - req_ready = 0.
  - slice_a = a_q[2*idx+1:2*idx], slice_b likewise; slice_op = op_q; slice_mode = mode_q; slice_cin = carry_q. All are combinational from registers, so the slice is settled within the same cycle.
  - Each clock edge in RUN:
    - f_q[2*idx+1:2*idx] <= slice_f
    - carry_q <= slice_cout & mode_q
    - eq_q <= eq_q & slice_eq
    - idx <= idx + 1
  - When idx == SLICES-1, the same edge captures the last slice and moves to DONE.
- Latency: a request accepted at edge k gives rsp_valid = 1 after edge k+SLICES (4 cycles for WIDTH=8).
- DONE:
  - rsp_valid = 1; rsp_f = f_q; rsp_cout = carry_q; rsp_zero = (f_q == 0); rsp_eq = eq_q.
  - Outputs are held stable while rsp_ready = 0 (no limit on backpressure duration).
  - On rsp_ready, return to IDLE the next edge. rsp_valid drops to 0; rsp_* data may hold its last value.
- Only IDLE accepts requests. req_valid in RUN/DONE is ignored and not queued. At best one request per SLICES+2 cycles.
- Logic mode (req_mode = 0): slice_cin is always 0 and rsp_cout = 0 regardless of req_cin or slice_cout.
- WIDTH = 2: RUN lasts exactly one cycle.
- Reset asserted in RUN or DONE aborts the operation and restores all reset values on that edge; no rsp_valid for the aborted request.
- Request and reset in the same cycle: reset wins, request dropped.
- idx width = clog2(SLICES), minimum 1; idx never wraps past SLICES-1.

Test Plan:
All scenarios use a behavioural slice model with op 0 = ADD and op 1 = XOR, WIDTH = 8.
1. ADD: a=0xA5, b=0x3C, cin=0, mode=1 -> rsp_f=0xE1, cout=0, zero=0, eq=0. rsp_valid exactly 4 cycles after the accept edge; slice_a sequence observed 01,01,10,10.
2. ADD: a=0xFF, b=0x01, cin=0, mode=1 -> rsp_f=0x00, cout=1, zero=1. Also a=0x00, b=0x00, cin=1 -> rsp_f=0x01, cout=0.
3. XOR: a=0x5A, b=0x5A, cin=1, mode=0 -> slice_cin=0 every RUN cycle, rsp_f=0x00, zero=1, eq=1, cout=0.
4. Backpressure: hold rsp_ready=0 for 6 cycles after rsp_valid -> all rsp_* stable, req_ready=0. rsp_ready=1 -> IDLE next edge, req_ready=1. A new request issued while busy produces no extra response.
5. Reset mid-op: assert rst_n=0 for one edge at idx=2 -> next cycle all outputs at reset values. A following request 0x10+0x20 returns 0x30 with no stale bits.
6. Back-to-back: 20 random requests with random rsp_ready stalls -> every rsp_f/rsp_cout matches the reference model, in order, one response per accepted request.
